// File: rtl/ttc3_pkg.sv
// Shared types and default sizing for the TeenyTinyTrustyCore secret vault.
package ttc3_pkg;

  localparam int NUM_SLOTS_DEF    = 4;
  localparam int SECRET_WIDTH_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_ZEROIZE,
    ST_ALARM
  } vault_state_e;

endpackage

// File: rtl/ttc3_vault_slot.sv
// One write-once secret slot: primary copy, complemented shadow copy and valid flag.
module ttc3_vault_slot
  import ttc3_pkg::*;
#(
  parameter int SECRET_WIDTH = SECRET_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    clr,
  input  logic [SECRET_WIDTH-1:0] wr_data,
  output logic                    valid,
  output logic [SECRET_WIDTH-1:0] secret,
  output logic                    mismatch
);

  logic [SECRET_WIDTH-1:0] primary;
  logic [SECRET_WIDTH-1:0] shadow;

  // Clear wins over write; a locked slot ignores further writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      primary <= '0;
      shadow  <= '0;
      valid   <= 1'b0;
    end else if (clr) begin
      primary <= '0;
      shadow  <= '0;
      valid   <= 1'b0;
    end else if (wr_en && !valid) begin
      primary <= wr_data;
      shadow  <= ~wr_data;
      valid   <= 1'b1;
    end
  end

  // An empty slot also reports mismatch; callers must qualify with valid.
  assign secret   = primary;
  assign mismatch = (primary != ~shadow);

`ifdef FORMAL
  a_locked_stable: assert property (@(posedge clock) disable iff (reset)
    (valid && !clr) |=> (primary == $past(primary) && shadow == $past(shadow)));
`endif

endmodule

// File: rtl/ttc3_secret_vault.sv
// Multi-slot write-once secret store with integrity-checked KDF read port,
// sequenced zeroize and sticky tamper alarm.
module ttc3_secret_vault
  import ttc3_pkg::*;
#(
  parameter  int NUM_SLOTS    = NUM_SLOTS_DEF,
  parameter  int SECRET_WIDTH = SECRET_WIDTH_DEF,
  localparam int SLOT_W       = $clog2(NUM_SLOTS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [SLOT_W-1:0]       wr_slot,
  input  logic [SECRET_WIDTH-1:0] wr_data,
  output logic                    wr_err,
  input  logic                    rd_req,
  input  logic [SLOT_W-1:0]       rd_slot,
  output logic                    rd_ack,
  output logic [SECRET_WIDTH-1:0] rd_data,
  output logic                    rd_err,
  input  logic                    zeroize_req,
  output logic                    zeroize_done,
  output logic [NUM_SLOTS-1:0]    slot_valid,
  output logic                    alarm,
  output logic                    busy
);

  vault_state_e            state;
  logic [SLOT_W-1:0]       rd_slot_q;
  logic [SLOT_W-1:0]       zero_cnt;
  logic                    alarm_ack_q;
  logic                    wr_accept;
  logic                    in_read;
  logic                    read_ok;
  logic [NUM_SLOTS-1:0]    slot_wr_en;
  logic [NUM_SLOTS-1:0]    slot_clr;
  logic [NUM_SLOTS-1:0]    slot_mismatch;
  logic [SECRET_WIDTH-1:0] slot_secret [NUM_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      ttc3_vault_slot #(
        .SECRET_WIDTH(SECRET_WIDTH)
      ) u_slot (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (slot_wr_en[gi]),
        .clr      (slot_clr[gi]),
        .wr_data  (wr_data),
        .valid    (slot_valid[gi]),
        .secret   (slot_secret[gi]),
        .mismatch (slot_mismatch[gi])
      );
    end
  endgenerate

  assign busy      = (state != ST_IDLE);
  assign wr_ready  = (state == ST_IDLE) && !zeroize_req && !rd_req;
  assign wr_accept = wr_valid && wr_ready;

  always_comb begin
    slot_wr_en = '0;
    slot_clr   = '0;
    if (wr_accept) slot_wr_en[wr_slot] = 1'b1;
    if (state == ST_ZEROIZE) slot_clr[zero_cnt] = 1'b1;
  end

  // Read response is combinational from READ; the ALARM-state reply is a
  // registered flag so it lands one cycle after the request.
  assign in_read = (state == ST_READ);
  assign read_ok = slot_valid[rd_slot_q] && !slot_mismatch[rd_slot_q];
  assign rd_ack  = in_read || alarm_ack_q;
  assign rd_err  = (in_read && !read_ok) || alarm_ack_q;
  assign rd_data = (in_read && read_ok) ? slot_secret[rd_slot_q] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      rd_slot_q    <= '0;
      zero_cnt     <= '0;
      wr_err       <= 1'b0;
      zeroize_done <= 1'b0;
      alarm        <= 1'b0;
      alarm_ack_q  <= 1'b0;
    end else begin
      wr_err       <= 1'b0;
      zeroize_done <= 1'b0;
      alarm_ack_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (zeroize_req) begin
            zero_cnt <= '0;
            state    <= ST_ZEROIZE;
          end else if (rd_req) begin
            rd_slot_q <= rd_slot;
            state     <= ST_READ;
          end else if (wr_valid) begin
            wr_err <= slot_valid[wr_slot];
          end
        end
        ST_READ: begin
          if (slot_valid[rd_slot_q] && slot_mismatch[rd_slot_q]) begin
            alarm    <= 1'b1;
            zero_cnt <= '0;
            state    <= ST_ZEROIZE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ZEROIZE: begin
          zero_cnt <= zero_cnt + 1'b1;
          if (zero_cnt == SLOT_W'(NUM_SLOTS - 1)) begin
            zeroize_done <= 1'b1;
            state        <= alarm ? ST_ALARM : ST_IDLE;
          end
        end
        ST_ALARM: begin
          alarm_ack_q <= rd_req && !alarm_ack_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FORMAL
  a_rd_data_gated: assert property (@(posedge clock) disable iff (reset)
    (rd_data != '0) |-> (rd_ack && !rd_err));
`endif

endmodule

// File: tb/tb_ttc3_secret_vault.sv
// Directed self-checking bench for ttc3_secret_vault.
module tb_ttc3_secret_vault;

  localparam int NS = 4;
  localparam int SW = 256;

  logic          clock;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_slot;
  logic [SW-1:0] wr_data;
  logic          wr_err;
  logic          rd_req;
  logic [1:0]    rd_slot;
  logic          rd_ack;
  logic [SW-1:0] rd_data;
  logic          rd_err;
  logic          zeroize_req;
  logic          zeroize_done;
  logic [NS-1:0] slot_valid;
  logic          alarm;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [SW-1:0] v_a5, v_11, v_3c, v_de, v_77, v_bad;
  int            n_cyc;
  logic          seen;

  ttc3_secret_vault #(.NUM_SLOTS(NS), .SECRET_WIDTH(SW)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_slot      (wr_slot),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .rd_req       (rd_req),
    .rd_slot      (rd_slot),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .zeroize_req  (zeroize_req),
    .zeroize_done (zeroize_done),
    .slot_valid   (slot_valid),
    .alarm        (alarm),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] s, input logic [SW-1:0] d);
    wr_valid = 1'b1;
    wr_slot  = s;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_slot(input logic [1:0] s);
    rd_req  = 1'b1;
    rd_slot = s;
    tick();
    rd_req  = 1'b0;
  endtask

  // Counts edges until zeroize_done is seen, bounded.
  task automatic wait_done(output int n, output logic found);
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      tick();
      n++;
      if (zeroize_done) found = 1'b1;
    end
  endtask

  initial begin
    v_a5 = {32{8'hA5}};
    v_11 = {32{8'h11}};
    v_3c = {32{8'h3C}};
    v_de = {8{32'hDEADBEEF}};
    v_77 = {64{4'h7}};

    reset = 1'b1; wr_valid = 1'b0; wr_slot = '0; wr_data = '0;
    rd_req = 1'b0; rd_slot = '0; zeroize_req = 1'b0;
    repeat (2) tick();
    check("rst_wr_ready", SW'(wr_ready), SW'(1));
    check("rst_busy", SW'(busy), SW'(0));
    check("rst_slot_valid", SW'(slot_valid), SW'(0));
    check("rst_rd_ack", SW'(rd_ack), SW'(0));
    check("rst_rd_data", rd_data, '0);
    check("rst_alarm", SW'(alarm), SW'(0));
    reset = 1'b0;
    tick();

    write_slot(2'd2, v_a5);
    check("wr2_slot_valid", SW'(slot_valid), SW'(4'b0100));
    check("wr2_wr_err", SW'(wr_err), SW'(0));

    read_slot(2'd2);
    check("rd2_ack", SW'(rd_ack), SW'(1));
    check("rd2_err", SW'(rd_err), SW'(0));
    check("rd2_data", rd_data, v_a5);
    check("rd2_busy", SW'(busy), SW'(1));
    tick();
    check("rd2_ack_gone", SW'(rd_ack), SW'(0));
    check("rd2_data_gone", rd_data, '0);
    check("rd2_idle", SW'(busy), SW'(0));

    write_slot(2'd2, v_11);
    check("rewr_wr_err", SW'(wr_err), SW'(1));
    tick();
    check("rewr_wr_err_pulse", SW'(wr_err), SW'(0));
    read_slot(2'd2);
    check("rewr_rd_data", rd_data, v_a5);
    tick();

    read_slot(2'd1);
    check("rd1_ack", SW'(rd_ack), SW'(1));
    check("rd1_err", SW'(rd_err), SW'(1));
    check("rd1_data", rd_data, '0);
    check("rd1_alarm", SW'(alarm), SW'(0));
    tick();

    write_slot(2'd0, v_3c);
    write_slot(2'd1, v_de);
    write_slot(2'd3, v_77);
    check("fill_slot_valid", SW'(slot_valid), SW'(4'b1111));
    zeroize_req = 1'b1;
    tick();
    zeroize_req = 1'b0;
    check("zero_busy", SW'(busy), SW'(1));
    wait_done(n_cyc, seen);
    check("zero_done_seen", SW'(seen), SW'(1));
    check("zero_done_edges", SW'(n_cyc + 1), SW'(5));
    check("zero_slot_valid", SW'(slot_valid), SW'(0));
    check("zero_idle", SW'(busy), SW'(0));
    tick();
    check("zero_done_pulse", SW'(zeroize_done), SW'(0));
    write_slot(2'd0, v_3c);
    check("zero_rewr_valid", SW'(slot_valid), SW'(4'b0001));
    check("zero_rewr_err", SW'(wr_err), SW'(0));
    read_slot(2'd0);
    check("zero_rewr_data", rd_data, v_3c);
    tick();

    write_slot(2'd3, v_77);
    v_bad = ~v_77 ^ SW'(1);
    force dut.g_slot[3].u_slot.shadow = v_bad;
    read_slot(2'd3);
    check("tamp_ack", SW'(rd_ack), SW'(1));
    check("tamp_err", SW'(rd_err), SW'(1));
    check("tamp_data", rd_data, '0);
    release dut.g_slot[3].u_slot.shadow;
    tick();
    check("tamp_alarm", SW'(alarm), SW'(1));
    check("tamp_busy", SW'(busy), SW'(1));
    wait_done(n_cyc, seen);
    check("tamp_done_seen", SW'(seen), SW'(1));
    check("tamp_slot_valid", SW'(slot_valid), SW'(0));
    tick();
    check("alarm_busy", SW'(busy), SW'(1));
    wr_valid = 1'b1; wr_slot = 2'd1; wr_data = v_de;
    #1;
    check("alarm_wr_ready", SW'(wr_ready), SW'(0));
    tick();
    wr_valid = 1'b0;
    check("alarm_wr_dropped", SW'(slot_valid), SW'(0));
    rd_req = 1'b1; rd_slot = 2'd0;
    #1;
    check("alarm_rd_not_yet", SW'(rd_ack), SW'(0));
    tick();
    rd_req = 1'b0;
    check("alarm_rd_ack", SW'(rd_ack), SW'(1));
    check("alarm_rd_err", SW'(rd_err), SW'(1));
    check("alarm_rd_data", rd_data, '0);
    zeroize_req = 1'b1;
    tick();
    zeroize_req = 1'b0;
    check("alarm_zero_ignored", SW'(zeroize_done), SW'(0));
    tick();
    check("alarm_sticky", SW'(alarm), SW'(1));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_alarm", SW'(alarm), SW'(0));
    tick();
    write_slot(2'd0, v_3c);
    write_slot(2'd1, v_de);
    zeroize_req = 1'b1; rd_req = 1'b1; rd_slot = 2'd0;
    wr_valid = 1'b1; wr_slot = 2'd2; wr_data = v_a5;
    #1;
    check("race_wr_ready", SW'(wr_ready), SW'(0));
    tick();
    zeroize_req = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    check("race_no_ack", SW'(rd_ack), SW'(0));
    check("race_wr_dropped", SW'(slot_valid), SW'(4'b0011));
    tick();
    check("race_slot0_cleared", SW'(slot_valid), SW'(4'b0010));
    check("race_no_ack2", SW'(rd_ack), SW'(0));
    reset = 1'b1;
    #1;
    check("midz_slot_valid", SW'(slot_valid), SW'(0));
    check("midz_busy", SW'(busy), SW'(0));
    check("midz_wr_ready", SW'(wr_ready), SW'(1));
    check("midz_done", SW'(zeroize_done), SW'(0));
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (zeroize_done) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (5) begin
      tick();
      if (zeroize_done) seen = 1'b1;
    end
    check("midz_no_done", SW'(seen), SW'(0));
    check("midz_idle", SW'(busy), SW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttc3_secret_vault.md
# ttc3_secret_vault

Multi-slot, write-once secret store for TeenyTinyTrustyCore, generalising single-secret DUS storage. It holds NUM_SLOTS independent secrets (DUS, provisioning keys, attestation seeds), each writable once until reset or zeroize. Secrets leave the block only through a handshaked, integrity-checked port to the internal KDF. The block adds a sequenced zeroize and a sticky tamper alarm. Sits between the fuse/OTP loader and the KDF; no path to top-level ports.

## Interface
- NUM_SLOTS, 4, number of secret slots (≥2, power of two)
- SECRET_WIDTH, 256, bits per secret
- SLOT_W (localparam), $clog2(NUM_SLOTS), slot index width

- clock  in  1  clock
- reset  in  1  asynchronous, active-high; clears all storage and state
- wr_valid  in  1  loader write request
- wr_ready  out  1  write may be accepted this cycle
- wr_slot  in  SLOT_W  target slot
- wr_data  in  SECRET_WIDTH  secret value
- wr_err  out  1  one-cycle pulse: write to locked slot rejected
- rd_req  in  1  KDF read request
- rd_slot  in  SLOT_W  requested slot
- rd_ack  out  1  one-cycle pulse completing a read
- rd_data  out  SECRET_WIDTH  secret; '0 whenever rd_ack=0 or rd_err=1
- rd_err  out  1  qualifies rd_ack: slot empty, integrity failure, or alarm
- zeroize_req  in  1  request wipe of all slots
- zeroize_done  out  1  one-cycle pulse when wipe completes
- slot_valid  out  NUM_SLOTS  per-slot lock/valid flags
- alarm  out  1  sticky integrity-failure flag
- busy  out  1  state ≠ IDLE

## Operation
- Per slot: primary register, shadow register (bitwise complement), valid bit. Write stores data and ~data and sets valid.
- FSM states: IDLE, READ, ZEROIZE, ALARM.
- IDLE priority: zeroize_req > rd_req > wr_valid. wr_ready = IDLE && !zeroize_req && !rd_req.
- Write (IDLE, accepted): slot not valid → store and set valid; slot valid → no change, wr_err pulses next cycle. Stay IDLE.
- rd_req in IDLE: latch rd_slot, go to READ.
- READ, one cycle: compare primary against ~shadow for the latched slot.
  - Slot invalid → rd_ack=1, rd_err=1, next state IDLE.
  - Valid and match → rd_ack=1, rd_data=secret, next state IDLE.
  - Mismatch → rd_ack=1, rd_err=1, rd_data='0, alarm set, next state ZEROIZE.
- ZEROIZE: a counter walks slot 0..NUM_SLOTS-1, one slot per cycle, clearing primary, shadow and valid.
  - After the last slot, zeroize_done pulses.
  - Next state is ALARM if alarm=1, else IDLE. Slots are writable again in IDLE.
- ALARM: terminal until reset. wr_ready=0; zeroize_req is ignored; rd_req is answered one cycle later with rd_ack=1, rd_err=1.
- Requests during READ/ZEROIZE are not accepted. The requester holds rd_req/wr_valid; reads are level-sampled only in IDLE.

## Timing
- Reset values: wr_ready=1 (IDLE), all other outputs 0, slot_valid='0, rd_data='0.
- Write: accepted on edge N; slot_valid visible on cycle N+1; wr_err, if any, high on N+1 only.
- Read: rd_req sampled in IDLE on edge N; rd_ack/rd_data valid during cycle N+1 (combinational from READ state); IDLE again at N+2.
- Zeroize: request on edge N; slots cleared on edges N+1..N+NUM_SLOTS; zeroize_done high during cycle N+NUM_SLOTS+1.
- Reset asserted mid-read or mid-zeroize: immediate clear, no ack/done pulse.
- Back-to-back reads: one per 2 cycles.

## Structure
- ttc3_pkg: vault_state_e enum, default NUM_SLOTS/SECRET_WIDTH constants.
- Sub-module ttc3_vault_slot: one slot (primary, shadow, valid, write-once logic, mismatch output), instantiated NUM_SLOTS times via generate. The FSM, arbitration and zeroize counter stay in the top.
- FORMAL block: valid slot content never changes except by zeroize or reset; rd_data='0 unless rd_ack && !rd_err.

## Test plan
- Write slot 2 = 0xA5..A5 → slot_valid=4'b0100; read slot 2 → rd_ack, rd_err=0, rd_data=0xA5..A5, on the cycle after the request.
- Rewrite slot 2 with 0x11..11 → wr_err pulses once; subsequent read still returns 0xA5..A5.
- Read empty slot 1 → rd_ack=1, rd_err=1, rd_data=0.
- Fill all 4 slots, pulse zeroize_req → done after exactly 5 cycles, slot_valid=0; rewrite slot 0 succeeds.
- Force a shadow bit flip in slot 3, then read slot 3 → rd_err=1, alarm=1, zeroize runs, FSM ends in ALARM; later writes see wr_ready=0, reads get rd_err.
- Same-cycle zeroize_req, rd_req and wr_valid → zeroize wins, no rd_ack, write dropped; assert reset during zeroize → all outputs reset values, no zeroize_done.
